ifetch_pc_unit: RTL
===================

// Module: ifetch_pc_unit
// PURPOSE
//   Instruction-fetch / PC stage directly downstream of the ALU's branch outputs.
//   - Holds the program counter and selects the next PC from sequential, branch (ALU Addr_Result/Zero), jump/jal and jr targets.
//   - Reads the instruction ROM synchronously and presents Instruction aligned with the current PC.
//   - Supports a stall (hold) and a UART program-load mode that rewrites the ROM.
// PARAMETERS
//   ROM_ADDR_W   14             word-address width of instruction ROM (16K words)
//   RESET_PC     32'h0000_0000  PC after reset and after a program load
// PORTS
//   clock        in   1   single clock; all state updates on posedge
//   reset        in   1   synchronous, active-high
//   Addr_Result  in   32  branch target as WORD address (PC_plus_4[31:2] + imm)
//   Zero         in   1   ALU result-is-zero flag
//   Read_data_1  in   32  rs value, jr target (byte address)
//   Branch       in   1   beq
//   nBranch      in   1   bne
//   Jmp          in   1   j
//   Jal          in   1   jal
//   Jr           in   1   jr
//   hold         in   1   stall request; freezes PC and Instruction
//   upg_en       in   1   program-load mode request
//   upg_wen      in   1   ROM write strobe (valid only in LOAD)
//   upg_adr      in   ROM_ADDR_W  ROM word address to write
//   upg_dat      in   32  ROM write data
//   upg_done     in   1   loader finished
//   Instruction  out  32  instruction at PC
//   PC           out  32  current PC (byte address)
//   PC_plus_4    out  32  PC + 4 (combinational, feeds ALU and jal link)
//   fetch_valid  out  1   Instruction is valid and may be executed this cycle
//   addr_fault   out  1   sticky: a jr target had bits [1:0] != 0
// BEHAVIOUR
//   Reset: PC=RESET_PC, Instruction=0, fetch_valid=0, addr_fault=0, state=BOOT.
//   States:
//   - BOOT: one cycle, fetching RESET_PC; -> RUN (-> LOAD if upg_en).
//   - RUN: fetch_valid=1; hold -> HOLD; upg_en -> LOAD.
//   - HOLD: PC/Instruction frozen, fetch_valid=0; !hold -> RUN; upg_en -> LOAD.
//   - LOAD: fetch_valid=0; PC=RESET_PC; upg_wen writes upg_dat to ROM[upg_adr]; upg_done & !upg_en -> BOOT.
//   next_pc priority, first match wins:
//   1. reset or LOAD -> RESET_PC.
//   2. hold or HOLD -> PC.
//   3. Jr -> {Read_data_1[31:2],2'b00}; set addr_fault if Read_data_1[1:0] != 0.
//   4. Jmp|Jal -> {PC_plus_4[31:28], Instruction[25:0], 2'b00}.
//   5. (Branch&Zero)|(nBranch&!Zero) -> {Addr_Result[29:0], 2'b00}.
//   6. else PC_plus_4.
//   Control inputs are ignored unless fetch_valid=1.
//   Zero-latency fetch: ROM read address = next_pc[ROM_ADDR_W+1:2], registered on the same edge that loads PC.
//   - Instruction therefore always matches PC, with no bubble in RUN.
//   - The only bubbles are BOOT and the first cycle after HOLD/LOAD exit.
//   Width rules:
//   - PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 -> 0.
//   - ROM indexing uses PC[ROM_ADDR_W+1:2] only, so addresses alias modulo ROM size.
//   Simultaneous events: reset beats all; upg_en beats hold; Jr beats Jmp/Branch.
//   Reset mid-LOAD aborts the load (partial ROM contents kept) and goes to BOOT.
//   addr_fault clears only on reset.
// STRUCTURE
//   Shared package cpu_defs:
//   - fetch state encoding (BOOT/RUN/HOLD/LOAD), RESET_PC default, ROM_ADDR_W default.
//   - J/JAL/BEQ/BNE opcode constants.
//   One sub-module, prgrom_sp: single-port synchronous BRAM (write-first), address mux between upg_adr (LOAD) and next_pc.
// TESTING
//   1. reset for 2 cycles, ROM[0]=32'h2001_0005 -> BOOT one cycle; then PC=0, Instruction=32'h2001_0005, fetch_valid=1.
//   2. PC=0x10, Branch=1, Zero=1, Addr_Result=0x0000_0008 -> PC=0x20; same with Zero=0 -> PC=0x14.
//   3. PC=0x40, Jal=1, Instruction[25:0]=26'h000_0100 -> PC=0x400; PC_plus_4 had been 0x44.
//   4. Jr=1, Read_data_1=0x0000_0033 -> PC=0x30 and addr_fault=1, sticky until reset.
//   5. hold high 3 cycles at PC=0x8 -> PC/Instruction unchanged and fetch_valid=0; release -> RUN at 0x8 then 0xC.
//   6. upg_en, write ROM[0]=32'hDEAD_BEEF, upg_done -> BOOT; Instruction=32'hDEAD_BEEF at PC=0; reset asserted mid-LOAD -> BOOT.

Source files
------------

// File: rtl/ifetch_pc_unit_pkg.sv
// rtl/ifetch_pc_unit_pkg.sv - shared fetch-stage definitions (package cpu_defs)
package cpu_defs;

    localparam int          ROM_ADDR_W_DEF = 14;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_LOAD = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus_4,
                                                input logic [31:0] instr);
        return {pc_plus_4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_pc_unit_prgrom_sp.sv
// rtl/ifetch_pc_unit_prgrom_sp.sv - single-port write-first instruction ROM with loader address mux
module prgrom_sp #(
    parameter int ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              rd_en_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] upg_adr_i,
    input  logic [31:0]       upg_dat_i,
    input  logic [ADDR_W-1:0] fetch_adr_i,
    output logic [31:0]       dout_o
);

    logic [31:0]       mem_q [0:(2**ADDR_W)-1];
    logic [31:0]       dout_q;
    logic [ADDR_W-1:0] addr;
    logic              we;

    assign addr   = load_i ? upg_adr_i : fetch_adr_i;
    // A reset landing on a load write aborts that write; earlier writes survive.
    assign we     = load_i & wen_i & ~rst_i;
    assign dout_o = dout_q;

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[addr] <= upg_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q <= '0;
        end else if (rd_en_i) begin
            dout_q <= we ? upg_dat_i : mem_q[addr];
        end
    end

endmodule

// File: rtl/ifetch_pc_unit.sv
// rtl/ifetch_pc_unit.sv - PC register, next-PC select and zero-latency instruction fetch
module ifetch_pc_unit
    import cpu_defs::*;
#(
    parameter int          ROM_ADDR_W = ROM_ADDR_W_DEF,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           Addr_Result,
    input  logic                  Zero,
    input  logic [31:0]           Read_data_1,
    input  logic                  Branch,
    input  logic                  nBranch,
    input  logic                  Jmp,
    input  logic                  Jal,
    input  logic                  Jr,
    input  logic                  hold,
    input  logic                  upg_en,
    input  logic                  upg_wen,
    input  logic [ROM_ADDR_W-1:0] upg_adr,
    input  logic [31:0]           upg_dat,
    input  logic                  upg_done,
    output logic [31:0]           Instruction,
    output logic [31:0]           PC,
    output logic [31:0]           PC_plus_4,
    output logic                  fetch_valid,
    output logic                  addr_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  next_pc;
    logic         fault_q;
    logic         br_taken;
    logic         rd_en;
    logic         unused_addr_hi;

    assign unused_addr_hi = ^Addr_Result[31:30];

    // A hold request drops fetch_valid at once so the stalled instruction is not issued twice.
    assign fetch_valid = (state_q == ST_RUN) && !hold;
    assign PC          = pc_q;
    assign PC_plus_4   = pc_q + 32'd4;
    assign addr_fault  = fault_q;
    assign br_taken    = (Branch && Zero) || (nBranch && !Zero);
    assign rd_en       = (state_q == ST_LOAD) || (state_q == ST_BOOT) || fetch_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = upg_en ? ST_LOAD : ST_RUN;
            ST_RUN: begin
                if (upg_en)    state_d = ST_LOAD;
                else if (hold) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (upg_en)     state_d = ST_LOAD;
                else if (!hold) state_d = ST_RUN;
            end
            ST_LOAD: begin
                if (upg_done && !upg_en) state_d = ST_BOOT;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // BOOT, HOLD and a held RUN cycle all re-present the current PC.
    always_comb begin
        next_pc = PC_plus_4;
        if (state_q == ST_LOAD) begin
            next_pc = RESET_PC;
        end else if (!fetch_valid) begin
            next_pc = pc_q;
        end else if (Jr) begin
            next_pc = {Read_data_1[31:2], 2'b00};
        end else if (Jmp || Jal) begin
            next_pc = jump_target(PC_plus_4, Instruction);
        end else if (br_taken) begin
            next_pc = {Addr_Result[29:0], 2'b00};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= next_pc;
            if (fetch_valid && Jr && (Read_data_1[1:0] != 2'b00)) begin
                fault_q <= 1'b1;
            end
        end
    end

    prgrom_sp #(
        .ADDR_W(ROM_ADDR_W)
    ) u_prgrom (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (state_q == ST_LOAD),
        .rd_en_i    (rd_en),
        .wen_i      (upg_wen),
        .upg_adr_i  (upg_adr),
        .upg_dat_i  (upg_dat),
        .fetch_adr_i(next_pc[ROM_ADDR_W+1:2]),
        .dout_o     (Instruction)
    );

endmodule
